// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_WIDTH = 4;

endpackage

// File: rtl/sub4b.sv
// Combinational subtractor: a - b with a borrow-out flag.
module sub4b #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o   = full[WIDTH-1:0];
  assign borrow_o = full[WIDTH];

endmodule

// File: rtl/div4b.sv
// Unsigned restoring divider: one shift-and-subtract iteration per clock.
// A zero divisor bypasses the iterations and reports all-ones / dividend.
module div4b
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic             zpend_q, zpend_d;

  logic [WIDTH:0]   rem_shift, diff;
  logic             borrow, fits;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // Dividend register doubles as the quotient shift register.
  assign rem_shift = {rem_q, a_q[WIDTH-1]};

  sub4b #(.WIDTH(WIDTH + 1)) u_sub (
    .a_i      (rem_shift),
    .b_i      ({1'b0, b_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // The kept difference must also fit back into WIDTH bits.
  assign fits    = ~(borrow | diff[WIDTH]);
  assign rem_nxt = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_nxt = {a_q[WIDTH-2:0], fits};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      zpend_q <= zpend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    zpend_d = zpend_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          rem_d   = '0;
          state_d = RUN;
          // Zero divisor spends one silent cycle in RUN before reporting.
          if (b_i != '0) begin
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            zpend_d = 1'b0;
          end else begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            zpend_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (zpend_q) begin
          q_d     = '1;
          r_d     = a_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          zpend_d = 1'b0;
          state_d = DONE;
        end else begin
          a_d   = quo_nxt;
          rem_d = rem_nxt;
          if (cnt_q == '0) begin
            q_d     = quo_nxt;
            r_d     = rem_nxt;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q_o    = q_q;
  assign r_o    = r_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dz_o   = dz_q;

endmodule

// File: doc/div4b.md
DIV4B -- requirements
Module: div4b

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
REQ-005 a_i  input  WIDTH  dividend, unsigned; captured on the accepting edge.
REQ-006 b_i  input  WIDTH  divisor, unsigned; captured on the accepting edge.
REQ-007 q_o  output  WIDTH  quotient, registered.
REQ-008 r_o  output  WIDTH  remainder, registered.
REQ-009 busy_o  output  1  high while an operation is in progress (RUN).
REQ-010 done_o  output  1  one-cycle pulse on result completion.
REQ-011 dz_o  output  1  divide-by-zero flag for the last result; held with q_o/r_o.

Function
REQ-012 Behaviour: unsigned restoring division by shift-and-subtract; result satisfies a = q*b + r with r < b for b != 0.
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE/DONE + start_i=1 + b_i!=0 -> RUN.
- Operands latched; partial remainder cleared; iteration counter loaded with WIDTH-1.
REQ-015 IDLE/DONE + start_i=1 + b_i==0 -> DONE on the next edge.
- q_o = all ones, r_o = a_i, dz_o=1, done_o=1 for that cycle.
REQ-016 Each RUN cycle performs exactly one iteration:
- partial remainder shifted left by one, dividend MSB shifted in;
- trial difference computed WIDTH+1 bits wide;
- borrow=0: difference kept and quotient bit set to 1; otherwise remainder restored and quotient bit set to 0.
REQ-017 RUN -> DONE after exactly WIDTH iterations; q_o, r_o and dz_o=0 update on that edge, and done_o=1 for one cycle.
REQ-018 Latency: accepting edge = cycle 0.
- b!=0: done_o high in cycle WIDTH, busy_o high in cycles 1..WIDTH-1 and low in cycle WIDTH.
- b==0: done_o high in cycle 1.
REQ-019 DONE -> IDLE after one cycle unless start_i=1, which starts a new operation (back-to-back; no bubble required).
REQ-020 start_i in RUN: ignored; operands, counter and outputs unaffected.
REQ-021 q_o, r_o and dz_o: hold the last result until the next completion and do not change during RUN.
REQ-022 Widths:
- Iteration counter: $clog2(WIDTH) bits; no wrap beyond WIDTH iterations.
- No truncation of the trial difference before the borrow test.

Reset
REQ-023 rst_ni=0: all of the following are forced immediately (asynchronously), including mid-operation:
- FSM to IDLE;
- q_o=0, r_o=0, busy_o=0, done_o=0, dz_o=0;
- counter and operand registers to 0.
REQ-024 An operation interrupted by reset is discarded; no done_o pulse follows reset release.
REQ-025 First start_i accepted: the first rising edge with rst_ni=1.

Structure
REQ-026 Shared package div_pkg holds:
- the state enum (IDLE, RUN, DONE);
- the default WIDTH constant.
REQ-027 One sub-module, sub4b: WIDTH-parameterised combinational subtractor.
- Outputs: difference and borrow.
- Instantiated once for the trial subtraction; all sequencing stays in div4b.

Verification
REQ-028 WIDTH=4, a=13, b=4 -> q_o=3, r_o=1, dz_o=0, done_o=1 exactly 4 cycles after the accepting edge.
REQ-029 a=7, b=0 -> done_o=1 one cycle after acceptance with q_o=4'hF, r_o=7, dz_o=1, busy_o never high.
REQ-030 Boundary operands:
- a=15, b=1 -> q_o=15, r_o=0;
- a=3, b=5 -> q_o=0, r_o=3;
- a=0, b=9 -> q_o=0, r_o=0.
REQ-031 Start 13/4, then start_i=1 with 15/1 in cycle 2 -> second request ignored; result 3/1.
- Start 15/1 in the done_o cycle -> accepted back-to-back, result 15/0 four cycles later.
REQ-032 Start 13/4, assert rst_ni=0 in cycle 2 -> all outputs 0 immediately, state IDLE, no done_o after release.
- Fresh 9/2 after release -> q_o=4, r_o=1.
REQ-033 Randomised sweep of all 256 operand pairs (WIDTH=4) against a reference model: a=q*b+r, r<b for b!=0, and the REQ-018 latency on every transaction.
